// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared HD44780 constants and text-buffer FSM encoding
package lcd_pkg;

  localparam int LCD_COLS        = 16;
  localparam int LCD_FRAME_BYTES = 2 * LCD_COLS + 2;

  localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } lcd_state_e;

endpackage

// File: rtl/lcd_cell_ram.sv
// rtl/lcd_cell_ram.sv - 2-row character cell array, one write port, clear-all, async read
module lcd_cell_ram
  import lcd_pkg::*;
#(
  parameter int         COLS      = LCD_COLS,
  parameter logic [7:0] FILL_CHAR = ASCII_SPACE,
  localparam int        AW        = $clog2(COLS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          clr_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [2**AW];

  // Clear wins over a same-cycle write so the screen is guaranteed blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= FILL_CHAR;
    end else if (clr_i) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= FILL_CHAR;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lcd_text_buffer.sv
// rtl/lcd_text_buffer.sv - 2x16 text frame buffer streaming DDRAM commands and characters to the LCD driver
module lcd_text_buffer
  import lcd_pkg::*;
#(
  parameter int         COLS      = LCD_COLS,
  parameter logic [7:0] LINE1_CMD = LCD_CMD_LINE1,
  parameter logic [7:0] LINE2_CMD = LCD_CMD_LINE2,
  parameter logic [7:0] FILL_CHAR = ASCII_SPACE,
  localparam int        CW        = $clog2(COLS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        wr_row,
  // One extra bit so out-of-range columns can be presented and rejected.
  input  logic [CW:0] wr_col,
  input  logic [7:0]  wr_char,
  input  logic        clear,
  input  logic        byte_req,
  input  logic        frame_abort,
  output logic        byte_valid,
  output logic        byte_rs,
  output logic [7:0]  byte_data,
  output logic        frame_done,
  output logic        frame_pending
);

  localparam int          IW          = $clog2(2 * COLS + 2);
  localparam logic [IW-1:0] ROW1_IDX  = IW'(COLS + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(2 * COLS + 1);

  lcd_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          dirty_q, dirty_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;

  logic          wr_ok, buf_change;
  logic          is_cmd;
  logic [7:0]    cmd_byte;
  logic          rd_row;
  logic [CW-1:0] rd_col;
  logic [7:0]    rd_char;

  assign wr_ok      = wr_en && (wr_col < (CW + 1)'(COLS));
  assign buf_change = clear || wr_ok;

  lcd_cell_ram #(
    .COLS      (COLS),
    .FILL_CHAR (FILL_CHAR)
  ) u_cells (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (wr_ok),
    .waddr_i ({wr_row, wr_col[CW-1:0]}),
    .wdata_i (wr_char),
    .clr_i   (clear),
    .raddr_i ({rd_row, rd_col}),
    .rdata_o (rd_char)
  );

  // Map frame index to either a line command or a {row, col} cell read.
  always_comb begin
    is_cmd   = 1'b0;
    cmd_byte = LINE1_CMD;
    rd_row   = 1'b0;
    rd_col   = '0;
    if (idx_q == '0) begin
      is_cmd = 1'b1;
    end else if (idx_q < ROW1_IDX) begin
      rd_col = CW'(idx_q - IW'(1));
    end else if (idx_q == ROW1_IDX) begin
      is_cmd   = 1'b1;
      cmd_byte = LINE2_CMD;
    end else begin
      rd_row = 1'b1;
      rd_col = CW'(idx_q - ROW1_IDX - IW'(1));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dirty_d = dirty_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    rs_d    = rs_q;
    data_d  = data_q;
    if (frame_abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      dirty_d = 1'b1;
    end else if (byte_req) begin
      valid_d = 1'b1;
      rs_d    = ~is_cmd;
      data_d  = is_cmd ? cmd_byte : rd_char;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_STREAM;
          idx_d   = IW'(1);
          dirty_d = 1'b0;
        end
        default: begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      endcase
    end
    // Any buffer change, even one racing a frame start, leaves a redraw pending.
    if (buf_change) dirty_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dirty_q <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dirty_q <= dirty_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  assign byte_valid    = valid_q;
  assign byte_rs       = rs_q;
  assign byte_data     = data_q;
  assign frame_done    = done_q;
  assign frame_pending = dirty_q;

endmodule
